// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the 2R1W register file write port.
// Optional write-to-read bypass is enabled with `define REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int DLEN       = 32,
    parameter int ALEN       = 5,
    parameter int STARVE_LIM = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_a_valid,
    output logic             o_a_ready,
    input  logic [ALEN-1:0]  i_a_waddr,
    input  logic [DLEN-1:0]  i_a_wdata,
    input  logic             i_b_valid,
    output logic             o_b_ready,
    input  logic [ALEN-1:0]  i_b_waddr,
    input  logic [DLEN-1:0]  i_b_wdata,
    output logic             o_wen,
    output logic [ALEN-1:0]  o_waddr,
    output logic [DLEN-1:0]  o_wdata,
    input  logic [ALEN-1:0]  i_raddr_a,
    input  logic [ALEN-1:0]  i_raddr_b,
    input  logic [DLEN-1:0]  i_rf_rdata_a,
    input  logic [DLEN-1:0]  i_rf_rdata_b,
    output logic [DLEN-1:0]  o_rdata_a,
    output logic [DLEN-1:0]  o_rdata_b,
    output logic [CNT_W-1:0] o_conflict_cnt
);

    localparam int WAIT_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(STARVE_LIM);
    localparam bit GUARD = (STARVE_LIM > 0);

    typedef enum logic {
        PRIO_A,
        FORCE_B
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              a_xfer;
    logic              b_xfer;
    logic              starve;

    always_comb begin
        o_a_ready = 1'b0;
        o_b_ready = 1'b0;
        if (!rst) begin
            unique case (state)
                PRIO_A: begin
                    o_a_ready = 1'b1;
                    o_b_ready = ~i_a_valid;
                end
                FORCE_B: begin
                    o_b_ready = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign a_xfer = i_a_valid && o_a_ready;
    assign b_xfer = i_b_valid && o_b_ready;

    // Counter saturates at the limit; the state change fires on the edge it gets there.
    always_comb begin
        wait_nxt  = wait_cnt;
        state_nxt = state;
        if (!i_b_valid || b_xfer) begin
            wait_nxt = '0;
        end else if (wait_cnt != WAIT_LIM) begin
            wait_nxt = wait_cnt + 1'b1;
        end
        starve = GUARD && i_b_valid && !b_xfer && (wait_nxt == WAIT_LIM);
        unique case (state)
            PRIO_A: begin
                if (starve) state_nxt = FORCE_B;
            end
            FORCE_B: begin
                if (b_xfer || !i_b_valid) state_nxt = PRIO_A;
            end
            default: state_nxt = PRIO_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PRIO_A;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_wen   <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
        end else if (a_xfer) begin
            o_wen   <= |i_a_waddr;
            o_waddr <= i_a_waddr;
            o_wdata <= i_a_wdata;
        end else if (b_xfer) begin
            o_wen   <= |i_b_waddr;
            o_waddr <= i_b_waddr;
            o_wdata <= i_b_wdata;
        end else begin
            o_wen   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_conflict_cnt <= '0;
        end else if (i_a_valid && i_b_valid && (o_conflict_cnt != '1)) begin
            o_conflict_cnt <= o_conflict_cnt + 1'b1;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign o_rdata_a = (o_wen && (o_waddr == i_raddr_a) && (|i_raddr_a))
                       ? o_wdata : i_rf_rdata_a;
    assign o_rdata_b = (o_wen && (o_waddr == i_raddr_b) && (|i_raddr_b))
                       ? o_wdata : i_rf_rdata_b;
`else
    logic raddr_unused;
    assign raddr_unused = ^{i_raddr_a, i_raddr_b};
    assign o_rdata_a    = i_rf_rdata_a;
    assign o_rdata_b    = i_rf_rdata_b;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (STARVE_LIM = 4).
// Bypass expectations follow REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_arbiter;

    localparam int DLEN  = 32;
    localparam int ALEN  = 5;
    localparam int CNT_W = 16;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, b_valid;
    logic             a_ready, b_ready;
    logic [ALEN-1:0]  a_waddr, b_waddr;
    logic [DLEN-1:0]  a_wdata, b_wdata;
    logic             wen;
    logic [ALEN-1:0]  waddr;
    logic [DLEN-1:0]  wdata;
    logic [ALEN-1:0]  raddr_a, raddr_b;
    logic [DLEN-1:0]  rf_rdata_a, rf_rdata_b;
    logic [DLEN-1:0]  rdata_a, rdata_b;
    logic [CNT_W-1:0] conflict_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DLEN(DLEN), .ALEN(ALEN), .STARVE_LIM(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .i_a_valid(a_valid), .o_a_ready(a_ready),
        .i_a_waddr(a_waddr), .i_a_wdata(a_wdata),
        .i_b_valid(b_valid), .o_b_ready(b_ready),
        .i_b_waddr(b_waddr), .i_b_wdata(b_wdata),
        .o_wen(wen), .o_waddr(waddr), .o_wdata(wdata),
        .i_raddr_a(raddr_a), .i_raddr_b(raddr_b),
        .i_rf_rdata_a(rf_rdata_a), .i_rf_rdata_b(rf_rdata_b),
        .o_rdata_a(rdata_a), .o_rdata_b(rdata_b),
        .o_conflict_cnt(conflict_cnt)
    );

    task automatic test_reset;
        rst = 1'b1;
        a_valid = 1'b1; a_waddr = 5'd3; a_wdata = 32'h1;
        b_valid = 1'b1; b_waddr = 5'd4; b_wdata = 32'h2;
        raddr_a = '0; raddr_b = '0; rf_rdata_a = '0; rf_rdata_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready got %b exp 0", a_ready); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready got %b exp 0", b_ready); end
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL rst_wen got %b exp 0", wen); end
        checks++; if (waddr !== 5'd0) begin errors++; $display("FAIL rst_waddr got %0d exp 0", waddr); end
        checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", wdata); end
        checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL rst_conflict got %0d exp 0", conflict_cnt); end
        a_valid = 1'b0; b_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL post_rst_wen got %b exp 0", wen); end
    endtask

    task automatic test_a_only;
        a_valid = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_only_ready got %b exp 1", a_ready); end
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL a_only_wen got %b exp 1", wen); end
        checks++; if (waddr !== 5'd5) begin errors++; $display("FAIL a_only_waddr got %0d exp 5", waddr); end
        checks++; if (wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL a_only_wdata got %h exp deadbeef", wdata); end
        @(negedge clk);
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL a_only_idle_wen got %b exp 0", wen); end
        checks++; if (waddr !== 5'd5) begin errors++; $display("FAIL a_only_hold_waddr got %0d exp 5", waddr); end
    endtask

    task automatic test_both;
        a_valid = 1'b1; a_waddr = 5'd1; a_wdata = 32'h11;
        b_valid = 1'b1; b_waddr = 5'd2; b_wdata = 32'h22;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL both_ready got %b exp 10", {a_ready, b_ready}); end
        @(negedge clk);
        checks++; if ({wen, waddr, wdata} !== {1'b1, 5'd1, 32'h11}) begin errors++; $display("FAIL both_first_write got %b/%0d/%h exp 1/1/11", wen, waddr, wdata); end
        a_valid = 1'b0;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL both_b_ready got %b exp 1", b_ready); end
        @(negedge clk);
        b_valid = 1'b0;
        checks++; if ({wen, waddr, wdata} !== {1'b1, 5'd2, 32'h22}) begin errors++; $display("FAIL both_second_write got %b/%0d/%h exp 1/2/22", wen, waddr, wdata); end
        checks++; if (conflict_cnt !== 16'd1) begin errors++; $display("FAIL both_conflict got %0d exp 1", conflict_cnt); end
    endtask

    task automatic test_starve;
        a_valid = 1'b1; a_waddr = 5'd3; a_wdata = 32'h33;
        b_valid = 1'b1; b_waddr = 5'd4; b_wdata = 32'h44;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) begin
                @(negedge clk);
                checks++; if ({wen, waddr} !== {1'b1, 5'd3}) begin errors++; $display("FAIL starve_a_write%0d got %b/%0d exp 1/3", i, wen, waddr); end
            end
            #1;
            checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL starve_wait%0d got %b exp 10", i, {a_ready, b_ready}); end
        end
        @(negedge clk);
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL starve_force got %b exp 01", {a_ready, b_ready}); end
        @(negedge clk);
        checks++; if ({wen, waddr, wdata} !== {1'b1, 5'd4, 32'h44}) begin errors++; $display("FAIL starve_b_write got %b/%0d/%h exp 1/4/44", wen, waddr, wdata); end
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL starve_back_prio got %b exp 10", {a_ready, b_ready}); end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        checks++; if ({wen, waddr} !== {1'b1, 5'd3}) begin errors++; $display("FAIL starve_after_write got %b/%0d exp 1/3", wen, waddr); end
        checks++; if (conflict_cnt !== 16'd7) begin errors++; $display("FAIL starve_conflict got %0d exp 7", conflict_cnt); end
    endtask

    task automatic test_reset_mid;
        a_valid = 1'b1; a_waddr = 5'd6; a_wdata = 32'h66;
        b_valid = 1'b1; b_waddr = 5'd9; b_wdata = 32'h99;
        repeat (3) @(negedge clk);
        checks++; if ({wen, waddr} !== {1'b1, 5'd6}) begin errors++; $display("FAIL mid_pre_write got %b/%0d exp 1/6", wen, waddr); end
        rst = 1'b1;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL mid_rst_ready got %b exp 00", {a_ready, b_ready}); end
        @(negedge clk);
        rst = 1'b0;
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL mid_wen got %b exp 0", wen); end
        checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL mid_conflict got %0d exp 0", conflict_cnt); end
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) @(negedge clk);
            #1;
            checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL mid_wait%0d got %b exp 10", i, {a_ready, b_ready}); end
        end
        @(negedge clk);
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL mid_force got %b exp 01", {a_ready, b_ready}); end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        checks++; if ({wen, waddr, wdata} !== {1'b1, 5'd9, 32'h99}) begin errors++; $display("FAIL mid_b_write got %b/%0d/%h exp 1/9/99", wen, waddr, wdata); end
    endtask

    task automatic test_x0;
        b_valid = 1'b1; b_waddr = 5'd0; b_wdata = 32'hFFFFFFFF;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL x0_b_ready got %b exp 1", b_ready); end
        @(negedge clk);
        b_valid = 1'b0;
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL x0_wen got %b exp 0", wen); end
        checks++; if (wdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL x0_wdata got %h exp ffffffff", wdata); end
        raddr_a = 5'd0; rf_rdata_a = 32'h0;
        #1;
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL x0_read got %h exp 0", rdata_a); end
    endtask

    task automatic test_bypass;
        logic [DLEN-1:0] exp_a;
        logic [DLEN-1:0] exp_b;
        a_valid = 1'b1; a_waddr = 5'd7; a_wdata = 32'h1234;
        @(negedge clk);
        a_valid = 1'b0;
        raddr_a = 5'd7; rf_rdata_a = 32'h0;
        raddr_b = 5'd7; rf_rdata_b = 32'h55;
        exp_a = BYP ? 32'h1234 : 32'h0;
        exp_b = BYP ? 32'h1234 : 32'h55;
        #1;
        checks++; if ({wen, waddr} !== {1'b1, 5'd7}) begin errors++; $display("FAIL byp_write got %b/%0d exp 1/7", wen, waddr); end
        checks++; if (rdata_a !== exp_a) begin errors++; $display("FAIL byp_rdata_a got %h exp %h", rdata_a, exp_a); end
        checks++; if (rdata_b !== exp_b) begin errors++; $display("FAIL byp_rdata_b got %h exp %h", rdata_b, exp_b); end
        raddr_a = 5'd8; rf_rdata_a = 32'hABCD;
        #1;
        checks++; if (rdata_a !== 32'hABCD) begin errors++; $display("FAIL byp_miss got %h exp abcd", rdata_a); end
        @(negedge clk);
        raddr_a = 5'd7; rf_rdata_a = 32'h77;
        #1;
        checks++; if (rdata_a !== 32'h77) begin errors++; $display("FAIL byp_no_wen got %h exp 77", rdata_a); end
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_both();
        test_starve();
        test_reset_mid();
        test_x0();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 2R1W integer register file between two writeback sources: A (ALU, high priority) and B (LSU/load return).
- Fixed priority to A, with a starvation guard that forces a B grant after a bounded wait.
- The registered write command drives the register file write port directly.
- Optionally provides a write-to-read bypass for the write being committed this cycle.

Parameters:
- DLEN, 32, data width of one register.
- ALEN, 5, register address width (1<<ALEN registers).
- STARVE_LIM, 4, consecutive cycles B may wait while valid before it is forced; 0 = pure A priority, no guard.
- CNT_W, 16, width of the conflict statistics counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_a_valid  in  1  A has a writeback.
- o_a_ready  out  1  A accepted this cycle.
- i_a_waddr  in  ALEN  A destination register.
- i_a_wdata  in  DLEN  A data.
- i_b_valid  in  1  B has a writeback.
- o_b_ready  out  1  B accepted this cycle.
- i_b_waddr  in  ALEN  B destination register.
- i_b_wdata  in  DLEN  B data.
- o_wen  out  1  register file write enable, registered.
- o_waddr  out  ALEN  register file write address, registered.
- o_wdata  out  DLEN  register file write data, registered.
- i_raddr_a  in  ALEN  read port A address, as presented to the register file.
- i_raddr_b  in  ALEN  read port B address.
- i_rf_rdata_a  in  DLEN  raw register file read data, port A.
- i_rf_rdata_b  in  DLEN  raw register file read data, port B.
- o_rdata_a  out  DLEN  read data to the consumer, port A.
- o_rdata_b  out  DLEN  read data to the consumer, port B.
- o_conflict_cnt  out  CNT_W  saturating count of cycles with both valids high.

Behaviour:
- Handshake: a transfer occurs when valid && ready in the same cycle. At most one requester is granted per cycle. Ready is combinational from the valids and FSM state. Ready does not depend on any downstream back-pressure.
- FSM state PRIO_A (reset state):
  - o_a_ready = 1.
  - o_b_ready = ~i_a_valid.
- FSM state FORCE_B:
  - o_a_ready = 0.
  - o_b_ready = 1.
- Wait counter (width $clog2(STARVE_LIM+1)):
  - Cleared on reset, on a B transfer, or when i_b_valid = 0.
  - Otherwise increments each cycle B is valid and not granted.
- Transitions:
  - PRIO_A -> FORCE_B when STARVE_LIM != 0 and the counter reaches STARVE_LIM at a clock edge with B still valid and not granted.
  - FORCE_B -> PRIO_A on the B transfer.
  - If B deasserts valid while in FORCE_B, return to PRIO_A.
- Write register, latency 1 cycle from transfer to o_wen:
  - On a transfer, o_waddr/o_wdata take the granted source's values.
  - o_wen = 1 iff waddr != 0.
  - A transfer to x0 is accepted (ready high), but o_wen = 0. The register file must never see a write to x0.
  - With no transfer, o_wen = 0 next cycle. o_waddr/o_wdata hold their values.
- Reset values: o_wen = 0, o_waddr = 0, o_wdata = 0, o_conflict_cnt = 0, FSM = PRIO_A, wait counter = 0.
- o_a_ready/o_b_ready during reset: o_a_ready = 0 and o_b_ready = 0 while rst is high.
- Reset mid-operation: a pending command in the write register is discarded; o_wen = 0 on the cycle after reset is sampled.
- o_conflict_cnt: increments when i_a_valid && i_b_valid; saturates at all-ones.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - o_rdata_x = o_wdata when o_wen && o_waddr == i_raddr_x && i_raddr_x != 0.
  - Otherwise o_rdata_x = i_rf_rdata_x.
  - Purely combinational. Covers a same-cycle write/read of one register.
- Not defined: o_rdata_x = i_rf_rdata_x (pure pass-through); no comparators are synthesized.

Test Plan:
- Reset then A only, x5 = 0xDEADBEEF -> o_a_ready = 1 the same cycle; next cycle o_wen = 1, o_waddr = 5, o_wdata = 0xDEADBEEF.
- A and B both valid for one cycle (A x1 = 0x11, B x2 = 0x22); A drops next cycle -> A granted first, B second; o_wen pulses two consecutive cycles (x1, then x2); o_conflict_cnt = 1.
- STARVE_LIM = 4, A and B continuously valid:
  - B waits 4 cycles.
  - Cycle 5: o_a_ready = 0, o_b_ready = 1, B written.
  - Following cycle: back to A priority.
- B write to x0 with data 0xFFFFFFFF -> o_b_ready = 1; o_wen stays 0; a later read of x0 returns 0.
- rst asserted the cycle after an A transfer -> o_wen = 0 on the following cycle; FSM in PRIO_A; counters 0.
- With REGFILE_WB_BYPASS_EN, o_wen = 1, o_waddr = 7, o_wdata = 0x1234, i_raddr_a = 7, i_rf_rdata_a = 0 -> o_rdata_a = 0x1234. Without the macro -> o_rdata_a = 0.
